// File: rtl/bin_frame_source.sv
// bin_frame_source: reads N consecutive bins from a synchronous-read bin RAM
// on each frame request and emits them as one framed stream
// (data/sob/eob/valid). The FSM stays busy until the frame's eob has gone
// out, so consecutive frames are always separated by idle cycles.
module bin_frame_source #(
  parameter int DW           = 16,
  parameter int IMAG_PART_EN = 0,
  parameter int IODW         = IMAG_PART_EN ? DW*2 : DW,
  parameter int N            = 256,
  parameter int AW           = (N > 1) ? $clog2(N) : 1,
  parameter int RD_LATENCY   = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            overrun_o,
  output logic            rd_en_o,
  output logic [AW-1:0]   rd_addr_o,
  input  logic [IODW-1:0] rd_data_i,
  output logic [IODW-1:0] data_o,
  output logic            sob_o,
  output logic            eob_o,
  output logic            valid_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(N-1);

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_en_q, rd_en_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  valid_q, valid_d;
  logic                  sob_q, sob_d;
  logic                  eob_q, eob_d;
  logic [IODW-1:0]       data_q, data_d;

  // flag delay lines; index 0 is the read being issued this cycle
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LATENCY-1:0] sob_sr_q, sob_sr_d;
  logic [RD_LATENCY-1:0] eob_sr_q, eob_sr_d;
  logic [RD_LATENCY:0]   vld_pipe, sob_pipe, eob_pipe;

  assign vld_pipe = {vld_sr_q, rd_en_q};
  assign sob_pipe = {sob_sr_q, rd_en_q && (rd_addr_q == '0)};
  assign eob_pipe = {eob_sr_q, rd_en_q && (rd_addr_q == LAST)};

  // frame sequencing: address generation and busy/overrun decode
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    overrun_d = start_i && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = READ;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      READ: begin
        if (rd_addr_q == LAST) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // eob is on the output this cycle, so the frame is complete
        if (eob_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // align read flags with returning memory data and register the stream
  always_comb begin
    vld_sr_d = vld_pipe[RD_LATENCY-1:0];
    sob_sr_d = sob_pipe[RD_LATENCY-1:0];
    eob_sr_d = eob_pipe[RD_LATENCY-1:0];
    valid_d  = vld_pipe[RD_LATENCY];
    sob_d    = sob_pipe[RD_LATENCY];
    eob_d    = eob_pipe[RD_LATENCY];
    // data outside a frame is forced to zero so neighbours see padding
    data_d   = valid_d ? rd_data_i : '0;
  end

  // state and output registers; reset also flushes in-flight reads
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      vld_sr_q  <= '0;
      sob_sr_q  <= '0;
      eob_sr_q  <= '0;
      valid_q   <= 1'b0;
      sob_q     <= 1'b0;
      eob_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_sr_q  <= vld_sr_d;
      sob_sr_q  <= sob_sr_d;
      eob_sr_q  <= eob_sr_d;
      valid_q   <= valid_d;
      sob_q     <= sob_d;
      eob_q     <= eob_d;
      data_q    <= data_d;
    end
  end

  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign valid_o   = valid_q;
  assign sob_o     = sob_q;
  assign eob_o     = eob_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_bin_frame_source.sv
// Directed bench for bin_frame_source: three configurations
// (A: N=4 lat 2, B: N=1 lat 2, C: complex DW=8 N=2 lat 1), each with a
// memory model, checked cycle by cycle against hand-derived timing.
module tb_bin_frame_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        busy;
    logic        ovr;
    logic        rd_en;
    logic [7:0]  addr;
    logic        valid;
    logic        sob;
    logic        eob;
    logic [15:0] data;
  } obs_t;

  obs_t cap [0:63];

  // ---- DUT A: N=4, RD_LATENCY=2, real 16-bit
  logic a_start = 1'b0, a_busy, a_ovr, a_rd_en, a_valid, a_sob, a_eob;
  logic [1:0]  a_addr, a_ad1, a_ad2;
  logic        a_en1, a_en2;
  logic [15:0] a_rdata, a_data;
  bin_frame_source #(.DW(16), .IMAG_PART_EN(0), .N(4), .RD_LATENCY(2)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(a_start), .busy_o(a_busy),
    .overrun_o(a_ovr), .rd_en_o(a_rd_en), .rd_addr_o(a_addr),
    .rd_data_i(a_rdata), .data_o(a_data), .sob_o(a_sob), .eob_o(a_eob),
    .valid_o(a_valid));
  always @(posedge clk) begin
    a_en1 <= a_rd_en; a_en2 <= a_en1; a_ad1 <= a_addr; a_ad2 <= a_ad1;
  end
  assign a_rdata = a_en2 ? (16'h0010 + {14'h0, a_ad2}) : 16'hDEAD;

  // ---- DUT B: N=1, RD_LATENCY=2
  logic b_start = 1'b0, b_busy, b_ovr, b_rd_en, b_valid, b_sob, b_eob;
  logic [0:0]  b_addr, b_ad1, b_ad2;
  logic        b_en1, b_en2;
  logic [15:0] b_rdata, b_data;
  bin_frame_source #(.DW(16), .IMAG_PART_EN(0), .N(1), .RD_LATENCY(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start), .busy_o(b_busy),
    .overrun_o(b_ovr), .rd_en_o(b_rd_en), .rd_addr_o(b_addr),
    .rd_data_i(b_rdata), .data_o(b_data), .sob_o(b_sob), .eob_o(b_eob),
    .valid_o(b_valid));
  always @(posedge clk) begin
    b_en1 <= b_rd_en; b_en2 <= b_en1; b_ad1 <= b_addr; b_ad2 <= b_ad1;
  end
  assign b_rdata = b_en2 ? (16'h0010 + {15'h0, b_ad2}) : 16'hBEEF;

  // ---- DUT C: complex, DW=8, N=2, RD_LATENCY=1
  logic c_start = 1'b0, c_busy, c_ovr, c_rd_en, c_valid, c_sob, c_eob;
  logic [0:0]  c_addr, c_ad1;
  logic        c_en1;
  logic [15:0] c_rdata, c_data;
  bin_frame_source #(.DW(8), .IMAG_PART_EN(1), .N(2), .RD_LATENCY(1)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(c_start), .busy_o(c_busy),
    .overrun_o(c_ovr), .rd_en_o(c_rd_en), .rd_addr_o(c_addr),
    .rd_data_i(c_rdata), .data_o(c_data), .sob_o(c_sob), .eob_o(c_eob),
    .valid_o(c_valid));
  always @(posedge clk) begin
    c_en1 <= c_rd_en; c_ad1 <= c_addr;
  end
  assign c_rdata = c_en1 ? (c_ad1[0] ? 16'h7F80 : 16'h807F) : 16'h5A5A;

  // Cycle c is sampled at its falling edge, then that cycle's start/reset
  // inputs are driven ahead of the rising edge that ends it.
  task automatic run(input int dut, input int ncyc, input logic [63:0] smask,
                     input logic [63:0] rmask);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (dut)
        0: cap[c] = '{a_busy, a_ovr, a_rd_en, {6'h0, a_addr}, a_valid, a_sob, a_eob, a_data};
        1: cap[c] = '{b_busy, b_ovr, b_rd_en, {7'h0, b_addr}, b_valid, b_sob, b_eob, b_data};
        default: cap[c] = '{c_busy, c_ovr, c_rd_en, {7'h0, c_addr}, c_valid, c_sob, c_eob, c_data};
      endcase
      a_start = (dut == 0) && smask[c];
      b_start = (dut == 1) && smask[c];
      c_start = (dut == 2) && smask[c];
      rst_n   = !rmask[c];
    end
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; rst_n = 1'b1;
  endtask

  // expected DUT A outputs k cycles after a frame was accepted
  function automatic obs_t exp_a(input int k);
    obs_t e;
    e = '0;
    e.busy  = (k >= 1 && k <= 7);
    e.rd_en = (k >= 1 && k <= 4);
    e.addr  = e.rd_en ? 8'(k - 1) : 8'h0;
    e.valid = (k >= 4 && k <= 7);
    e.data  = e.valid ? 16'(16'h10 + k - 4) : 16'h0;
    e.sob   = (k == 4);
    e.eob   = (k == 7);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({a_busy, a_ovr, a_rd_en, a_addr, a_valid, a_sob, a_eob, a_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a got busy=%b rd_en=%b addr=%0d valid=%b data=%h want all 0",
               a_busy, a_rd_en, a_addr, a_valid, a_data);
    end
    tests_run++;
    if ({b_busy, b_ovr, b_rd_en, b_addr, b_valid, b_sob, b_eob, b_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b got busy=%b rd_en=%b valid=%b data=%h want all 0",
               b_busy, b_rd_en, b_valid, b_data);
    end
    tests_run++;
    if ({c_busy, c_ovr, c_rd_en, c_addr, c_valid, c_sob, c_eob, c_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_c got busy=%b rd_en=%b valid=%b data=%h want all 0",
               c_busy, c_rd_en, c_valid, c_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    run(0, 12, 64'h1, 64'h0);
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (cap[c] !== exp_a(c)) begin
        tests_failed++;
        $display("FAIL single_frame c=%0d got %h want %h", c, cap[c], exp_a(c));
      end
    end
  endtask

  task automatic test_overrun();
    int nrd, nvld, nsob;
    run(0, 16, 64'h89, 64'h0);  // starts at cycles 0, 3, 7
    nrd = 0; nvld = 0; nsob = 0;
    for (int c = 0; c < 16; c++) begin
      nrd  += int'(cap[c].rd_en);
      nvld += int'(cap[c].valid);
      nsob += int'(cap[c].sob);
      tests_run++;
      if (cap[c].ovr !== (c == 4 || c == 8)) begin
        tests_failed++;
        $display("FAIL overrun c=%0d got %b want %b", c, cap[c].ovr, (c == 4 || c == 8));
      end
    end
    tests_run++;
    if (nrd != 4 || nvld != 4 || nsob != 1) begin
      tests_failed++;
      $display("FAIL overrun_one_frame got reads=%0d valids=%0d sobs=%0d want 4 4 1",
               nrd, nvld, nsob);
    end
    tests_run++;
    if (cap[7].eob !== 1'b1 || cap[7].busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_eob7 got eob=%b busy=%b want 1 1", cap[7].eob, cap[7].busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, want;
    run(0, 16, 64'hFFFF, 64'h0);  // start held high for cycles 0..15
    for (int c = 0; c < 16; c++) begin
      int k;
      k = (c < 8) ? c : c - 8;
      // busy, valid, sob, eob, overrun
      want = {(k >= 1 && k <= 7), (k >= 4 && k <= 7), (k == 4), (k == 7),
              ((c >= 2 && c <= 8) || c >= 10)};
      got  = {cap[c].busy, cap[c].valid, cap[c].sob, cap[c].eob, cap[c].ovr};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL back_to_back c=%0d got bvseo=%b want %b", c, got, want);
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_n1();
    obs_t e;
    run(1, 10, 64'h1, 64'h0);
    for (int c = 0; c < 10; c++) begin
      e = '0;
      e.busy  = (c >= 1 && c <= 4);
      e.rd_en = (c == 1);
      e.valid = (c == 4);
      e.sob   = (c == 4);
      e.eob   = (c == 4);
      e.data  = (c == 4) ? 16'h0010 : 16'h0;
      tests_run++;
      if (cap[c] !== e) begin
        tests_failed++;
        $display("FAIL n1 c=%0d got %h want %h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t e;
    run(0, 16, 64'h81, 64'h20);  // start at 0 and 7, reset at cycle 5
    for (int c = 0; c < 16; c++) begin
      if (c <= 5)      e = exp_a(c);
      else if (c <= 7) e = '0;
      else             e = exp_a(c - 7);
      tests_run++;
      if (cap[c] !== e) begin
        tests_failed++;
        $display("FAIL reset_mid_frame c=%0d got %h want %h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_imag();
    obs_t e;
    run(2, 8, 64'h1, 64'h0);
    for (int c = 0; c < 8; c++) begin
      e = '0;
      e.busy  = (c >= 1 && c <= 4);
      e.rd_en = (c == 1 || c == 2);
      e.addr  = (c == 2) ? 8'h1 : 8'h0;
      e.valid = (c == 3 || c == 4);
      e.sob   = (c == 3);
      e.eob   = (c == 4);
      e.data  = (c == 3) ? 16'h807F : (c == 4) ? 16'h7F80 : 16'h0;
      tests_run++;
      if (cap[c] !== e) begin
        tests_failed++;
        $display("FAIL imag c=%0d got %h want %h", c, cap[c], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_n1();
    test_reset_mid_frame();
    test_imag();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
